line_encoder_seq: RTL

//  Registered 8-line-to-3-bit encoder; the transmit side of the Line_Decoder one-hot interface.

---
 rtl/line_encoder_seq_if.sv | 24 ++
 rtl/line_encoder_seq.sv | 78 +++++++
 2 files changed

// File: rtl/line_encoder_seq_if.sv
// Request/handshake bundle between a line-request source and the line encoder.
// The master drives requests and Ready; the slave (encoder) returns the code and status.
interface line_encoder_seq_if;
  logic       Enable;
  logic [7:0] F_in;
  logic       Ready;
  logic       Clr_ovr;
  logic       A;
  logic       B;
  logic       C;
  logic       Valid;
  logic       Busy;
  logic       Overrun;

  modport master (
    output Enable, F_in, Ready, Clr_ovr,
    input  A, B, C, Valid, Busy, Overrun
  );

  modport slave (
    input  Enable, F_in, Ready, Clr_ovr,
    output A, B, C, Valid, Busy, Overrun
  );
endinterface

// File: rtl/line_encoder_seq.sv
// Registered 8-line-to-3-bit encoder: pending request set drained lowest line first,
// each line i presented as {A,B,C} = 7-i behind a Valid/Ready handshake.
module line_encoder_seq #(
  parameter bit CLEAR_ON_DISABLE = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  line_encoder_seq_if.slave bus
);

  logic [7:0] pend_p0;
  logic [2:0] abc_p1;
  logic       vld_p1;
  logic       ovr_q;

  logic       load_opp;
  logic [7:0] grant;
  logic       load;
  logic       ovr_set;
  logic [7:0] pend_nxt;

  // Isolate the lowest set bit: line 0 has the highest priority.
  function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  function automatic logic [2:0] code_of(input logic [7:0] onehot);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) code = 3'(7 - i);
    end
    return code;
  endfunction

  always_comb begin
    load_opp = !vld_p1 || bus.Ready;
    grant    = load_opp ? lowest_onehot(pend_p0) : 8'd0;
    load     = |grant;
    ovr_set  = bus.Enable && (|(bus.F_in & pend_p0 & ~grant));
    if (bus.Enable) begin
      pend_nxt = (pend_p0 & ~grant) | bus.F_in;
    end else if (CLEAR_ON_DISABLE) begin
      pend_nxt = 8'd0;
    end else begin
      pend_nxt = pend_p0 & ~grant;
    end
  end

  // Stage p0 -> p1: pending set feeds the output register on each load opportunity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p0 <= 8'd0;
      abc_p1  <= 3'd0;
      vld_p1  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pend_p0 <= pend_nxt;
      if (load_opp) begin
        vld_p1 <= load;
        if (load) abc_p1 <= code_of(grant);
      end
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (bus.Clr_ovr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.A       = abc_p1[2];
  assign bus.B       = abc_p1[1];
  assign bus.C       = abc_p1[0];
  assign bus.Valid   = vld_p1;
  assign bus.Busy    = (|pend_p0) || vld_p1;
  assign bus.Overrun = ovr_q;

endmodule
